// File: rtl/nx_fifo_drain.sv
// -----------------------------------------------------------------------------
// nx_fifo_drain
// -----------------------------------------------------------------------------
// Read-side partner of the nx_fifo show-ahead FIFO. Pops words whenever the
// FIFO has data and there is room locally, and presents them on a
// valid/ready stream driven straight from local flops. A two-entry skid
// buffer sits between the FIFO and the stream. Because of that buffer,
// fifo_ren never has to look at out_ready, and one word per clock can still
// be sustained.
//
// Parameters
//   WIDTH  data width, must match the attached FIFO
//   CNT_W  width of the delivered-beat counter (wraps, no saturation)
//
// Ports
//   clk         in   clock, single domain
//   rst         in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   FIFO head data (show-ahead), valid when !fifo_empty
//   fifo_ren    out  FIFO pop strobe (combinational, independent of out_ready)
//   clear       in   synchronous flush of the local buffer
//   out_valid   out  stream valid
//   out_data    out  stream data (zero while nothing is buffered)
//   out_ready   in   stream ready
//   out_count   out  number of accepted out_valid && out_ready beats
//   busy        out  local buffer holds at least one word
// -----------------------------------------------------------------------------
module nx_fifo_drain #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    // Buffer occupancy doubles as the FSM state.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [WIDTH-1:0] skid_head;
    logic [WIDTH-1:0] skid_over;
    logic             pop;
    logic             take;

    // The pop decision uses only local occupancy. Space is guaranteed when
    // occupancy is below two, so a word popped during a take cycle always
    // has somewhere to land. That keeps out_ready out of the ren path.
    always_comb begin
        pop      = !rst && !clear && !fifo_empty && (state != FULL);
        fifo_ren = pop;
    end

    // The stream outputs come straight from the state and head flops. The data
    // is masked to zero while empty, so a stale head word never shows up.
    always_comb begin
        out_valid = (state != EMPTY);
        busy      = (state != EMPTY);
        out_data  = (state != EMPTY) ? skid_head : '0;
        take      = out_valid && out_ready;
    end

    // Skid buffer and counter. clear drops the buffered words but still
    // counts a beat that is accepted in the same cycle. skid_head is always
    // the oldest word. skid_over only fills when the head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            skid_head <= '0;
            skid_over <= '0;
            out_count <= '0;
        end else begin
            if (take) begin
                out_count <= out_count + CNT_ONE;
            end
            if (clear) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (pop) begin
                            state     <= ONE;
                            skid_head <= fifo_rdata;
                        end
                    end
                    ONE: begin
                        if (pop && take) begin
                            skid_head <= fifo_rdata;
                        end else if (pop) begin
                            state     <= FULL;
                            skid_over <= fifo_rdata;
                        end else if (take) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (take) begin
                            state     <= ONE;
                            skid_head <= skid_over;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_nx_fifo_drain
// -----------------------------------------------------------------------------
// Directed bench for nx_fifo_drain. A queue stands in for the show-ahead
// FIFO. The bench drives the queue head onto fifo_rdata and pops the queue
// whenever fifo_ren was high at a clock edge. Expected values are written
// out by hand for each step. The counter is built with CNT_W=4, so the wrap
// case is reachable.
// -----------------------------------------------------------------------------
module tb_nx_fifo_drain;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_ren;
    logic             clear;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    logic [WIDTH-1:0] fifoQ[$];
    logic [WIDTH-1:0] expQ[$];
    logic             forceEmpty;
    int               popCount;
    int               takeCount;
    int               passCount;
    int               checkCount;

    nx_fifo_drain #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_ren  (fifo_ren),
        .clear     (clear),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit, so a hung DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Puts the model FIFO's head and empty flag onto the DUT inputs.
    task automatic applyStimulus();
        fifo_empty = forceEmpty || (fifoQ.size() == 0);
        fifo_rdata = (fifoQ.size() != 0) ? fifoQ[0] : '0;
    endtask

    // Runs one immediate-assertion comparison and keeps the tallies.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) begin
            passCount = passCount + 1;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advances one clock. The task samples the handshake before the edge,
    // updates the FIFO model after the edge, and then returns at negedge+1.
    task automatic step();
        logic renSeen;
        logic takeSeen;
        applyStimulus();
        #1;
        renSeen  = fifo_ren;
        takeSeen = out_valid && out_ready;
        @(posedge clk);
        if (renSeen && fifoQ.size() != 0) begin
            void'(fifoQ.pop_front());
            popCount = popCount + 1;
        end
        if (takeSeen) begin
            takeCount = takeCount + 1;
        end
        @(negedge clk);
        applyStimulus();
        #1;
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        int startTakes;
        int idx;
        int guard;

        passCount  = 0;
        checkCount = 0;
        popCount   = 0;
        takeCount  = 0;
        forceEmpty = 1'b0;
        rst        = 1'b1;
        clear      = 1'b0;
        out_ready  = 1'b0;
        fifoQ.push_back(4'h7);
        @(negedge clk);
        applyStimulus();
        #1;

        // Reset with a non-empty FIFO: no pops, all outputs at zero.
        checkOutput("rst_ren", fifo_ren, 1'b0);
        step();
        step();
        checkOutput("rst_ren2", fifo_ren, 1'b0);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_data", out_data, 4'h0);
        checkOutput("rst_count", out_count, 4'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_nopop", fifoQ.size(), 1);
        fifoQ.delete();
        rst = 1'b0;
        step();

        // Streaming 1..4 with out_ready high: one word per clock.
        out_ready = 1'b1;
        fifoQ = '{4'h1, 4'h2, 4'h3, 4'h4};
        step();
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("stream_valid%0d", k), out_valid, 1'b1);
            checkOutput($sformatf("stream_data%0d", k), out_data, k);
            step();
        end
        checkOutput("stream_drained", out_valid, 1'b0);
        checkOutput("stream_count", out_count, 4'd4);

        // Backpressure: exactly two pops, then the head holds word 5.
        out_ready = 1'b0;
        popCount  = 0;
        fifoQ = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        for (int k = 0; k < 4; k++) begin
            step();
        end
        checkOutput("bp_pops", popCount, 2);
        checkOutput("bp_ren", fifo_ren, 1'b0);
        checkOutput("bp_valid", out_valid, 1'b1);
        checkOutput("bp_hold", out_data, 4'h5);
        checkOutput("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_valid%0d", k), out_valid, 1'b1);
            checkOutput($sformatf("bp_data%0d", k), out_data, 5 + k);
            step();
        end
        checkOutput("bp_drained", out_valid, 1'b0);
        checkOutput("bp_count", out_count, 4'd9);

        // Clear while full (A,B held): both are dropped and C comes next.
        out_ready = 1'b0;
        fifoQ = '{4'hA, 4'hB, 4'hC};
        step();
        step();
        clear = 1'b1;
        #1;
        checkOutput("clr_full_ren", fifo_ren, 1'b0);
        step();
        clear = 1'b0;
        checkOutput("clr_full_valid", out_valid, 1'b0);
        checkOutput("clr_full_busy", busy, 1'b0);
        checkOutput("clr_full_count", out_count, 4'd9);
        out_ready = 1'b1;
        step();
        checkOutput("clr_c_data", out_data, 4'hC);
        step();
        checkOutput("clr_c_count", out_count, 4'd10);

        // Clear holding one word with a take in the same cycle. The take
        // counts, and the waiting FIFO word must not be popped.
        out_ready = 1'b0;
        fifoQ = '{4'hD, 4'hE};
        step();
        out_ready = 1'b1;
        clear     = 1'b1;
        #1;
        checkOutput("clr_take_ren", fifo_ren, 1'b0);
        step();
        clear = 1'b0;
        checkOutput("clr_take_valid", out_valid, 1'b0);
        checkOutput("clr_take_count", out_count, 4'd11);
        checkOutput("clr_take_fifo", fifoQ.size(), 1);
        step();
        checkOutput("clr_e_data", out_data, 4'hE);
        step();
        checkOutput("clr_e_count", out_count, 4'd12);

        // Empty interleave: fifo_empty toggles every clock and out_ready is
        // random. There must be no pop while empty, and order must be kept.
        fifoQ = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        expQ  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 80) begin
            forceEmpty = guard[0];
            out_ready  = 1'($urandom_range(0, 1));
            applyStimulus();
            #1;
            if (fifo_empty) begin
                checkOutput("ilv_no_underflow", fifo_ren, 1'b0);
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("ilv_order%0d", idx), out_data, expQ[idx]);
                idx = idx + 1;
            end
            step();
            guard = guard + 1;
        end
        forceEmpty = 1'b0;
        checkOutput("ilv_delivered", idx, 6);
        checkOutput("ilv_drained", out_valid, 1'b0);
        checkOutput("ilv_count", out_count, 4'd2);

        // Reset mid-burst drops the buffer but leaves the FIFO untouched.
        out_ready = 1'b0;
        fifoQ = '{4'h3, 4'h4, 4'h5};
        step();
        step();
        rst = 1'b1;
        #1;
        checkOutput("rstmid_ren", fifo_ren, 1'b0);
        step();
        rst = 1'b0;
        checkOutput("rstmid_valid", out_valid, 1'b0);
        checkOutput("rstmid_count", out_count, 4'd0);
        checkOutput("rstmid_fifo", fifoQ.size(), 1);

        // Counter wrap: 17 accepted beats since reset leave a count of 1.
        out_ready = 1'b1;
        step();
        checkOutput("wrap_first", out_data, 4'h5);
        step();
        checkOutput("wrap_count1", out_count, 4'd1);
        for (int k = 0; k < 16; k++) begin
            fifoQ.push_back(4'(k));
        end
        startTakes = takeCount;
        guard      = 0;
        while ((takeCount - startTakes) < 16 && guard < 60) begin
            step();
            guard = guard + 1;
        end
        checkOutput("wrap_beats", takeCount - startTakes, 16);
        checkOutput("wrap_count", out_count, 4'd1);
        checkOutput("wrap_idle", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
